// File: rtl/lk_rans_decoder.sv
// ---------------------------------------------------------------------------
// lk_rans_decoder
// Single-state rANS decoder for a 4-symbol alphabet with an 8-bit probability
// scale (frequency total 256). A small frequency table is loaded through the
// cfg_* port while idle. start kicks off a decode of sym_count symbols from a
// byte stream: two bytes seed the 16-bit state x, then every symbol costs one
// DECODE cycle, one EMIT cycle and, when x falls below 256, one RENORM byte.
// At the end the state must have returned to exactly 256, otherwise err is set.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg_we/sym/freq     frequency table write (ignored unless idle)
//   start, sym_count    decode request (ignored unless idle)
//   in_valid/data/ready compressed byte stream
//   out_valid/sym/ready decoded symbol stream
//   busy, done, err     status: not idle, end-of-job pulse, sticky error
//   dbg_state, dbg_x    FSM state and decoder state x, for observation only
//
// Handshakes: a beat transfers on a rising edge where valid and ready are both
// high. in_ready and out_valid depend only on the FSM state, so neither side
// has a combinational path from its own valid/ready to the other's.
// ---------------------------------------------------------------------------
module lk_rans_decoder #(
  parameter int SYMS       = 4,
  parameter int SCALE_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_sym,
  input  logic [8:0]  cfg_freq,
  input  logic        start,
  input  logic [7:0]  sym_count,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [1:0]  out_sym,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  dbg_state,
  output logic [15:0] dbg_x
);

  localparam logic [9:0]  TOTAL_M = 10'(1 << SCALE_BITS);
  localparam logic [15:0] X_FINAL = 16'(1 << SCALE_BITS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INIT_HI = 3'd1;
  localparam logic [2:0] S_INIT_LO = 3'd2;
  localparam logic [2:0] S_DECODE  = 3'd3;
  localparam logic [2:0] S_EMIT    = 3'd4;
  localparam logic [2:0] S_RENORM  = 3'd5;
  localparam logic [2:0] S_FINISH  = 3'd6;

  logic [2:0]  state;
  logic [15:0] x;
  logic [7:0]  remaining;
  logic [8:0]  freq [SYMS];

  // Cumulative frequency table. A total of 1024 wraps to 0 in 10 bits, which
  // is still rejected as != 256, so the narrow width cannot accept a bad table.
  logic [9:0] cum [SYMS];
  logic [9:0] total;

  always_comb begin
    total = '0;
    for (int i = 0; i < SYMS; i++) begin
      cum[i] = total;
      total  = total + {1'b0, freq[i]};
    end
  end

  // Symbol lookup for the current slot. Zero-frequency symbols have an empty
  // interval and can never match; with a valid table exactly one symbol does.
  logic [7:0]  slot;
  logic [1:0]  dec_sym;
  logic [8:0]  dec_freq;
  logic [9:0]  dec_cum;
  logic [17:0] dec_full;
  logic [15:0] x_dec;

  always_comb begin
    slot    = x[7:0];
    dec_sym = '0;
    for (int i = 0; i < SYMS; i++) begin
      if (({3'b0, slot} >= {1'b0, cum[i]}) &&
          ({3'b0, slot} < ({1'b0, cum[i]} + {2'b0, freq[i]})))
        dec_sym = i[1:0];
    end
    dec_freq = freq[dec_sym];
    dec_cum  = cum[dec_sym];
    // freq * (x >> 8) + (slot - cum), kept wide then truncated to 16 bits.
    dec_full = (18'(dec_freq) * 18'(x[15:8])) + 18'(slot) - 18'(dec_cum);
    x_dec    = dec_full[15:0];
  end

  assign in_ready  = (state == S_INIT_HI) || (state == S_INIT_LO) || (state == S_RENORM);
  assign out_valid = (state == S_EMIT);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;
  assign dbg_x     = x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      x         <= '0;
      remaining <= '0;
      out_sym   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < SYMS; i++) freq[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_we) freq[cfg_sym] <= cfg_freq;
          if (start) begin
            if (total != TOTAL_M) begin
              // Unusable table: report and stay idle.
              err  <= 1'b1;
              done <= 1'b1;
            end else begin
              err       <= 1'b0;
              remaining <= sym_count;
              state     <= S_INIT_HI;
            end
          end
        end
        S_INIT_HI: begin
          if (in_valid) begin
            x[15:8] <= in_data;
            state   <= S_INIT_LO;
          end
        end
        S_INIT_LO: begin
          if (in_valid) begin
            x[7:0] <= in_data;
            state  <= (remaining == 8'd0) ? S_FINISH : S_DECODE;
          end
        end
        S_DECODE: begin
          x         <= x_dec;
          out_sym   <= dec_sym;
          remaining <= remaining - 8'd1;
          state     <= S_EMIT;
        end
        S_EMIT: begin
          if (out_ready) begin
            if (x < 16'd256)             state <= S_RENORM;
            else if (remaining != 8'd0)  state <= S_DECODE;
            else                         state <= S_FINISH;
          end
        end
        S_RENORM: begin
          // x >= 1 here, so a single byte brings it back to >= 256.
          if (in_valid) begin
            x     <= {x[7:0], in_data};
            state <= (remaining != 8'd0) ? S_DECODE : S_FINISH;
          end
        end
        S_FINISH: begin
          err   <= (x != X_FINAL);
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lk_rans_decoder.sv
module tb_lk_rans_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_sym = '0;
  logic [8:0]  cfg_freq = '0;
  logic        start = 1'b0;
  logic [7:0]  sym_count = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [1:0]  out_sym;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  dbg_state;
  logic [15:0] dbg_x;

  lk_rans_decoder #(.SYMS(4), .SCALE_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_sym(cfg_sym), .cfg_freq(cfg_freq),
    .start(start), .sym_count(sym_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_sym(out_sym), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err),
    .dbg_state(dbg_state), .dbg_x(dbg_x)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  logic [1:0] exp_q[$];
  logic [1:0] obs_q[$];
  logic [7:0] byte_q[$];
  int         mf [4];
  int         m_used;
  int         m_x;
  logic       m_err;

  // Decodes byte_q with table mf using plain integer arithmetic.
  task automatic model_run(input int count);
    int x, slot, c, s, csym, k;
    exp_q.delete();
    x = int'(byte_q[0]) * 256 + int'(byte_q[1]);
    k = 2;
    for (int i = 0; i < count; i++) begin
      slot = x % 256;
      c = 0; s = 0; csym = 0;
      for (int j = 0; j < 4; j++) begin
        if (slot >= c && slot < c + mf[j]) begin
          s = j; csym = c;
        end
        c += mf[j];
      end
      x = (mf[s] * (x / 256) + slot - csym) % 65536;
      exp_q.push_back(s[1:0]);
      if (x < 256) begin
        x = x * 256 + int'(byte_q[k]);
        k++;
      end
    end
    m_used = k;
    m_x    = x;
    m_err  = (x != 256);
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_table(input int f0, input int f1, input int f2, input int f3);
    mf[0] = f0; mf[1] = f1; mf[2] = f2; mf[3] = f3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cfg_we = 1'b1; cfg_sym = 2'(i); cfg_freq = 9'(mf[i]);
    end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Runs one job: pulses start, feeds byte_q with in_valid active vpct% of
  // cycles, accepts symbols rpct% of cycles. With poke set, junk cfg writes
  // and start pulses are driven while the job runs.
  task automatic run_stream(input int count, input int vpct, input int rpct, input bit poke,
                            output int cycles, output int used, output logic got_done,
                            output logic got_err, output logic [15:0] fin_x);
    int idx;
    idx = 0; cycles = 0; got_done = 1'b0; got_err = 1'b0; fin_x = '0;
    obs_q.delete();
    @(negedge clk);
    start = 1'b1; sym_count = 8'(count);
    @(negedge clk);
    start = 1'b0;
    while (cycles < 3000) begin
      if (done) begin
        got_done = 1'b1; got_err = err; fin_x = dbg_x;
        break;
      end
      in_valid  = ($urandom_range(99) < vpct);
      in_data   = (idx < byte_q.size()) ? byte_q[idx] : 8'($urandom_range(255));
      out_ready = ($urandom_range(99) < rpct);
      if (poke) begin
        cfg_we = 1'b1; cfg_sym = 2'($urandom_range(3)); cfg_freq = 9'($urandom_range(256));
        start = 1'b1; sym_count = 8'($urandom_range(255));
      end
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) obs_q.push_back(out_sym);
      cycles++;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0; cfg_we = 1'b0; start = 1'b0;
    used = idx;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, out_sym, done, err, busy} !== 7'b0 || dbg_x !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%0b vld=%0b sym=%0d done=%0b err=%0b busy=%0b x=%0h, expected all 0",
               in_ready, out_valid, out_sym, done, err, busy, dbg_x);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got busy=%0b in_ready=%0b, expected 0 0", busy, in_ready);
    end
  endtask

  // One fixed scenario with a fully cooperative environment.
  task automatic check_fixed(input string name, input logic [1:0] exp_sym, input int exp_used,
                             input logic exp_err, input logic [15:0] exp_x);
    int cyc, used; logic gd, ge; logic [15:0] fx;
    run_stream(1, 100, 100, 1'b0, cyc, used, gd, ge, fx);
    n_cmp++;
    if (gd !== 1'b1) begin n_fail++; $display("FAIL %s_done: got %0b expected 1", name, gd); end
    n_cmp++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_sym) begin
      n_fail++;
      $display("FAIL %s_sym: got count=%0d sym=%0d expected count=1 sym=%0d", name, obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : 2'd0, exp_sym);
    end
    n_cmp++;
    if (used != exp_used) begin n_fail++; $display("FAIL %s_bytes: got %0d expected %0d", name, used, exp_used); end
    n_cmp++;
    if (ge !== exp_err) begin n_fail++; $display("FAIL %s_err: got %0b expected %0b", name, ge, exp_err); end
    n_cmp++;
    if (fx !== exp_x) begin n_fail++; $display("FAIL %s_final_x: got %0h expected %0h", name, fx, exp_x); end
    n_cmp++;
    if (cyc != 3 + 2 + (exp_used - 2)) begin
      n_fail++; $display("FAIL %s_cycles: got %0d expected %0d", name, cyc, 3 + 2 + (exp_used - 2));
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_done_pulse: got done=%0b busy=%0b expected 0 0", name, done, busy);
    end
  endtask

  task automatic test_basic();
    load_table(128, 64, 32, 32);
    byte_q = '{8'h02, 8'h00};
    check_fixed("basic", 2'd0, 2, 1'b0, 16'h0100);
  endtask

  task automatic test_renorm();
    load_table(1, 255, 0, 0);
    byte_q = '{8'h01, 8'h00, 8'h00};
    check_fixed("renorm", 2'd0, 3, 1'b0, 16'h0100);
  endtask

  task automatic test_bad_final();
    load_table(128, 64, 32, 32);
    byte_q = '{8'h01, 8'hC5, 8'h00};
    check_fixed("bad_final", 2'd2, 3, 1'b1, 16'h2500);
  endtask

  task automatic test_bad_table();
    logic saw_ready, saw_busy;
    load_table(100, 100, 0, 0);
    @(negedge clk);
    start = 1'b1; sym_count = 8'd1; in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || err !== 1'b1) begin
      n_fail++; $display("FAIL bad_table_flags: got done=%0b err=%0b expected 1 1", done, err);
    end
    saw_ready = in_ready; saw_busy = busy;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      saw_ready |= in_ready; saw_busy |= busy;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (saw_ready !== 1'b0 || saw_busy !== 1'b0) begin
      n_fail++; $display("FAIL bad_table_idle: got in_ready=%0b busy=%0b expected 0 0", saw_ready, saw_busy);
    end
    n_cmp++;
    if (err !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL bad_table_sticky: got err=%0b done=%0b expected 1 0", err, done);
    end
  endtask

  task automatic test_backpressure();
    int idx, k; logic [1:0] s0; logic [15:0] x0;
    load_table(128, 64, 32, 32);
    byte_q = '{8'h02, 8'h00};
    @(negedge clk);
    start = 1'b1; sym_count = 8'd1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; out_ready = 1'b0; idx = 0; k = 0;
    while (!out_valid && k < 20) begin
      in_data = (idx < 2) ? byte_q[idx] : 8'h00;
      if (in_ready) idx++;
      @(negedge clk);
      k++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_reach_emit: got out_valid=%0b expected 1", out_valid); end
    s0 = out_sym; x0 = dbg_x;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_sym !== s0 || in_ready !== 1'b0 || dbg_x !== x0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got vld=%0b sym=%0d rdy=%0b x=%0h expected 1 %0d 0 %0h",
                 i, out_valid, out_sym, in_ready, dbg_x, s0, x0);
      end
    end
    n_cmp++;
    if (s0 !== 2'd0 || x0 !== 16'h0100) begin
      n_fail++; $display("FAIL bp_values: got sym=%0d x=%0h expected 0 100", s0, x0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    k = 0;
    while (!done && k < 10) begin @(negedge clk); k++; end
    n_cmp++;
    if (done !== 1'b1 || err !== 1'b0) begin
      n_fail++; $display("FAIL bp_finish: got done=%0b err=%0b expected 1 0", done, err);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int idx, got, k; bit in_renorm;
    int cyc, used; logic gd, ge; logic [15:0] fx;
    load_table(1, 255, 0, 0);
    byte_q = '{8'h01, 8'h00};
    @(negedge clk);
    start = 1'b1; sym_count = 8'd1;
    @(negedge clk);
    start = 1'b0; idx = 0; got = 0; in_renorm = 0;
    for (k = 0; k < 20; k++) begin
      in_valid = (idx < 2); in_data = (idx < 2) ? byte_q[idx] : 8'h00; out_ready = 1'b1;
      if (got == 1 && in_ready) begin in_renorm = 1; break; end
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) got++;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if (!in_renorm) begin n_fail++; $display("FAIL rst_mid_reach_renorm: got %0b expected 1", in_renorm); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, out_sym, done, err, busy} !== 7'b0 || dbg_x !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got rdy=%0b vld=%0b sym=%0d done=%0b err=%0b busy=%0b x=%0h, expected all 0",
               in_ready, out_valid, out_sym, done, err, busy, dbg_x);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Table is cleared by reset, so a start before reloading is rejected.
    @(negedge clk);
    start = 1'b1; sym_count = 8'd1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_table_cleared: got done=%0b err=%0b busy=%0b expected 1 1 0", done, err, busy);
    end
    load_table(128, 64, 32, 32);
    byte_q = '{8'h02, 8'h00};
    run_stream(1, 100, 100, 1'b0, cyc, used, gd, ge, fx);
    n_cmp++;
    if (gd !== 1'b1 || ge !== 1'b0 || obs_q.size() != 1 || used != 2 || (obs_q.size() == 1 && obs_q[0] !== 2'd0)) begin
      n_fail++;
      $display("FAIL rst_mid_redecode: got done=%0b err=%0b nsym=%0d bytes=%0d expected 1 0 1 2", gd, ge, obs_q.size(), used);
    end
  endtask

  // Random tables / streams with random valid and ready behaviour.
  task automatic test_random(input int iters, input bit full_rate, input bit poke, input string name);
    int a, b, c, t, count, vpct, rpct, cyc, used;
    logic gd, ge; logic [15:0] fx;
    for (int it = 0; it < iters; it++) begin
      a = $urandom_range(256); b = $urandom_range(256); c = $urandom_range(256);
      if (a > b) begin t = a; a = b; b = t; end
      if (b > c) begin t = b; b = c; c = t; end
      if (a > b) begin t = a; a = b; b = t; end
      load_table(a, b - a, c - b, 256 - c);
      count = $urandom_range(12);
      byte_q.delete();
      for (int i = 0; i < count + 2; i++) byte_q.push_back(8'($urandom_range(255)));
      model_run(count);
      vpct = full_rate ? 100 : $urandom_range(100, 30);
      rpct = full_rate ? 100 : $urandom_range(100, 30);
      run_stream(count, vpct, rpct, poke, cyc, used, gd, ge, fx);
      n_cmp++;
      if (gd !== 1'b1) begin n_fail++; $display("FAIL %s_%0d_done: got %0b expected 1", name, it, gd); end
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
        n_fail++; $display("FAIL %s_%0d_nsym: got %0d expected %0d", name, it, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL %s_%0d_sym%0d: got %0d expected %0d", name, it, i, obs_q[i], exp_q[i]);
        end
      end
      n_cmp++;
      if (used != m_used) begin n_fail++; $display("FAIL %s_%0d_bytes: got %0d expected %0d", name, it, used, m_used); end
      n_cmp++;
      if (ge !== m_err || fx !== 16'(m_x)) begin
        n_fail++; $display("FAIL %s_%0d_final: got err=%0b x=%0h expected err=%0b x=%0h", name, it, ge, fx, m_err, 16'(m_x));
      end
      if (full_rate) begin
        n_cmp++;
        if (cyc != 3 + 2 * count + (m_used - 2)) begin
          n_fail++; $display("FAIL %s_%0d_cycles: got %0d expected %0d", name, it, cyc, 3 + 2 * count + (m_used - 2));
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_renorm();
    test_bad_final();
    test_bad_table();
    test_backpressure();
    test_reset_mid();
    test_random(25, 1'b0, 1'b0, "random");
    test_random(6, 1'b1, 1'b0, "back_to_back");
    test_random(6, 1'b1, 1'b1, "busy_ignore");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lk_rans_decoder.md
LK_RANS_DECODER -- requirements
Module: lk_rans_decoder

Interface
REQ-001 SHALL have parameter SYMS, default 4: alphabet size, fixed at 4 in this revision.
REQ-002 SHALL have parameter SCALE_BITS, default 8: probability scale, with frequency total M = 256.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port cfg_we, input, 1 bit: frequency table write strobe, accepted only in IDLE.
REQ-006 SHALL have port cfg_sym, input, 2 bits: table index written.
REQ-007 SHALL have port cfg_freq, input, 9 bits: frequency value, range 0..256.
REQ-008 SHALL have port start, input, 1 bit: single-cycle pulse, honoured only in IDLE.
REQ-009 SHALL have port sym_count, input, 8 bits: number of symbols to decode; sampled on start; 0 means decode none.
REQ-010 SHALL have ports in_valid (input, 1 bit), in_data (input, 8 bits) and in_ready (output, 1 bit): compressed byte stream, transfer when valid and ready are both high.
REQ-011 SHALL have ports out_valid (output, 1 bit), out_sym (output, 2 bits) and out_ready (input, 1 bit): decoded symbol stream, transfer when valid and ready are both high.
REQ-012 SHALL have ports busy (output, 1 bit), done (output, 1-cycle pulse) and err (output, 1 bit, sticky until next accepted start).

Function
REQ-013 SHALL hold freq[0..3] in registers; cum[s] = sum of freq[0..s-1], computed at 10-bit width.
REQ-014 SHALL use FSM states IDLE, INIT_HI, INIT_LO, DECODE, EMIT, RENORM, FINISH.
REQ-015 On start in IDLE: if cum total != 256, SHALL set err, pulse done the next cycle and remain in IDLE; otherwise SHALL clear err, latch sym_count into remaining and go to INIT_HI.
REQ-016 INIT_HI, then INIT_LO: each SHALL assert in_ready and consume one byte into the 16-bit state x, big-endian (x = {hi, lo}); they SHALL then go to DECODE, or to FINISH if remaining == 0.
REQ-017 in_ready SHALL be high only in INIT_HI, INIT_LO and RENORM.
REQ-018 DECODE (exactly 1 cycle):
- slot = x[7:0]
- s = the unique symbol with cum[s] <= slot < cum[s]+freq[s]
- x <= freq[s]*(x>>8) + slot - cum[s], 16-bit result
- out_sym <= s; remaining decrements; next state EMIT.
REQ-019 EMIT SHALL hold out_valid high and out_sym stable until out_ready is high; on transfer it SHALL go to RENORM if x < 256, else to DECODE if remaining != 0, else to FINISH.
REQ-020 RENORM SHALL wait for one byte and set x <= {x[7:0], in_data}; it SHALL then go to DECODE if remaining != 0, else to FINISH. One byte always suffices because x >= 1 after DECODE.
REQ-021 FINISH SHALL set err if x != 256, pulse done for one cycle and return to IDLE.
REQ-022 Latency from a DECODE cycle to out_valid SHALL be 1 cycle; with no stalls, throughput SHALL be 1 symbol per 2 cycles, or per 3 cycles when renormalising.
REQ-023 busy SHALL be high in every state except IDLE.
REQ-024 cfg_we while busy SHALL be ignored; start while busy SHALL be ignored.
REQ-025 A symbol with freq 0 SHALL never be decoded; a freq of 256 SHALL decode that symbol for every slot.

Reset
REQ-026 rst_n low SHALL asynchronously force the FSM to IDLE and set x = 0, remaining = 0, in_ready = 0, out_valid = 0, out_sym = 0, done = 0, err = 0, busy = 0, and all freq = 0.
REQ-027 Reset asserted mid-decode SHALL abort with no further handshakes; after release the frequency table SHALL be reloaded before the next start.

Verification
REQ-028 Scenario, basic decode: freq = {128, 64, 32, 32}, sym_count = 1, bytes 0x02, 0x00 -> out_sym = 0, no renorm byte requested, done pulses, err = 0.
REQ-029 Scenario, renormalisation: freq = {1, 255, 0, 0}, sym_count = 1, bytes 0x01, 0x00, 0x00 -> out_sym = 0, then one RENORM byte consumed, final x = 256, err = 0.
REQ-030 Scenario, bad final state: freq = {128, 64, 32, 32}, sym_count = 1, bytes 0x01, 0xC5, 0x00 -> out_sym = 2, x = 0x2500 at FINISH, err = 1.
REQ-031 Scenario, bad table: freq = {100, 100, 0, 0} with start -> no in_ready, done pulses, err = 1, busy stays 0.
REQ-032 Scenario, backpressure: hold out_ready low for 5 cycles during EMIT -> out_valid and out_sym stable, in_ready low, x unchanged.
REQ-033 Scenario, reset mid-stream: assert rst_n low in RENORM -> all outputs read 0 immediately; a fresh table plus start then decodes REQ-028 correctly.
